gost89_ofb_stream: RTL and testbench

GOST89_OFB_STREAM -- requirements
Module: gost89_ofb_stream

---
 rtl/gost89_ofb_stream.sv | 161 ++++++++++++++++
 tb/tb_gost89_ofb_stream.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gost89_ofb_stream.sv
// GOST 28147-89 encryption core wrapped as an output-feedback / counter-gamma stream
// cipher with valid/ready block handshakes; UNROLL rounds are evaluated per clock.
module gost89_ofb_stream #(
  parameter int           UNROLL = 1,
  parameter int           CNT_W  = 32,
  parameter logic [511:0] SBOX   = {
    64'h2BC96AF43850DE71, 64'h73AD0B4FC19652E8, 64'h0E34187BAC296FD5, 64'hC24BE390D618A5F7,
    64'hB9E35A076F4D128C, 64'h069C471EDAF2853B, 64'hF0DB74E1C5A93286, 64'h1F307D8E9B5A264C}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             iv_load,
  input  logic [63:0]      iv,
  input  logic [255:0]     key,
  input  logic             mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_data,
  output logic             busy,
  output logic [CNT_W-1:0] blk_cnt
);

  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8)) begin : g_bad_unroll
    $error("gost89_ofb_stream: UNROLL must be 1, 2, 4 or 8");
  end

  localparam logic [4:0] RND_STEP = 5'(UNROLL);
  localparam logic [4:0] LAST_RND = 5'(32 - UNROLL);

  typedef enum logic [2:0] {IDLE, INIT, READY, GEN, OUT} state_t;

  state_t         state, state_next;
  logic [255:0]   key_q;
  logic           mode_q;
  logic [63:0]    blk_q, blk_next;
  logic [63:0]    seed_q;     // {H, L} in counter mode, G in feedback mode
  logic [63:0]    data_q;
  logic [4:0]     rnd_q;
  logic [63:0]    enc_result;
  logic [32:0]    h_sum;
  logic [31:0]    h_inc, l_inc;
  logic           accept, last_rnd;

  function automatic logic [31:0] round_key(input logic [255:0] k, input logic [4:0] r);
    logic [2:0] j;
    j = (r < 5'd24) ? r[2:0] : ~r[2:0];
    return k[32*(7 - int'(j)) +: 32];
  endfunction

  function automatic logic [63:0] gost_round(input logic [63:0] b, input logic [31:0] k);
    logic [31:0] t, s;
    t = b[63:32] + k;
    s = '0;
    for (int i = 0; i < 8; i++) s[4*i +: 4] = SBOX[64*i + 4*int'(t[4*i +: 4]) +: 4];
    return {{s[20:0], s[31:21]} ^ b[31:0], b[63:32]};
  endfunction

  // NOTE: every variable assigned in an always_comb gets a value before any branch
  // or loop, so no path can leave it unassigned and infer a latch.
  always_comb begin
    blk_next = blk_q;
    for (int u = 0; u < UNROLL; u++)
      blk_next = gost_round(blk_next, round_key(key_q, rnd_q + 5'(u)));
  end

  assign enc_result = {blk_next[31:0], blk_next[63:32]};

  // Counter step: H wraps with end-around carry, L wraps mod 2^32.
  assign h_sum = {1'b0, seed_q[63:32]} + 33'h0_0101_0104;
  assign h_inc = h_sum[31:0] + {31'b0, h_sum[32]};
  assign l_inc = seed_q[31:0] + 32'h0101_0101;

  assign in_ready = (state == READY) && !iv_load;
  assign accept   = in_valid && in_ready;
  assign busy     = (state == INIT) || (state == GEN);
  assign last_rnd = (rnd_q == LAST_RND);

  always_comb begin
    state_next = state;
    if (iv_load) begin
      state_next = INIT;
    end else begin
      case (state)
        IDLE:    state_next = IDLE;
        INIT:    if (last_rnd)  state_next = READY;
        READY:   if (accept)    state_next = GEN;
        GEN:     if (last_rnd)  state_next = OUT;
        OUT:     if (out_ready) state_next = READY;
        default: state_next = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_q     <= '0;
      mode_q    <= 1'b0;
      blk_q     <= '0;
      seed_q    <= '0;
      data_q    <= '0;
      rnd_q     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      blk_cnt   <= '0;
    end else if (iv_load) begin
      key_q     <= key;
      mode_q    <= mode;
      blk_q     <= iv;
      rnd_q     <= '0;
      out_valid <= 1'b0;
      blk_cnt   <= '0;
    end else begin
      case (state)
        INIT: begin
          blk_q <= blk_next;
          rnd_q <= rnd_q + RND_STEP;
          if (last_rnd) seed_q <= enc_result;
        end
        READY: begin
          if (accept) begin
            data_q <= in_data;
            rnd_q  <= '0;
            if (!mode_q) begin
              seed_q <= {h_inc, l_inc};
              blk_q  <= {h_inc, l_inc};
            end else begin
              blk_q  <= seed_q;
            end
          end
        end
        GEN: begin
          blk_q <= blk_next;
          rnd_q <= rnd_q + RND_STEP;
          if (last_rnd) begin
            out_data  <= data_q ^ enc_result;
            out_valid <= 1'b1;
            if (mode_q) seed_q <= enc_result;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            blk_cnt   <= blk_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gost89_ofb_stream.sv
// Bench for gost89_ofb_stream: C-style GOST model, scoreboard queue, vector table and
// hand-written abort/reset/stall sequences over three instances.
module tb_gost89_ofb_stream;

  localparam logic [511:0] SBOX_TB = {
    64'h2BC96AF43850DE71, 64'h73AD0B4FC19652E8, 64'h0E34187BAC296FD5, 64'hC24BE390D618A5F7,
    64'hB9E35A076F4D128C, 64'h069C471EDAF2853B, 64'hF0DB74E1C5A93286, 64'h1F307D8E9B5A264C};

  logic         clk = 1'b0;
  logic         reset;
  logic         iv_load   [3];
  logic [63:0]  iv        [3];
  logic [255:0] key       [3];
  logic         mode      [3];
  logic         in_valid  [3];
  logic         in_ready  [3];
  logic [63:0]  in_data   [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic [63:0]  out_data  [3];
  logic         busy      [3];
  logic [31:0]  cnt_a, cnt_b;
  logic [1:0]   cnt_c;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];
  logic [63:0] ct[4];

  always #5 clk = ~clk;

  gost89_ofb_stream #(.UNROLL(1), .CNT_W(32)) u_a (
    .clk(clk), .reset(reset), .iv_load(iv_load[0]), .iv(iv[0]), .key(key[0]), .mode(mode[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
    .busy(busy[0]), .blk_cnt(cnt_a));

  gost89_ofb_stream #(.UNROLL(1), .CNT_W(32)) u_b (
    .clk(clk), .reset(reset), .iv_load(iv_load[1]), .iv(iv[1]), .key(key[1]), .mode(mode[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
    .busy(busy[1]), .blk_cnt(cnt_b));

  gost89_ofb_stream #(.UNROLL(8), .CNT_W(2)) u_c (
    .clk(clk), .reset(reset), .iv_load(iv_load[2]), .iv(iv[2]), .key(key[2]), .mode(mode[2]),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]),
    .busy(busy[2]), .blk_cnt(cnt_c));

  // ---------------- reference model ----------------
  function automatic int kidx(input int r);
    return (r < 24) ? (r % 8) : (7 - (r % 8));
  endfunction

  function automatic logic [31:0] f_tb(input logic [31:0] x, input logic [31:0] k);
    logic [511:0] sb;
    logic [63:0]  row;
    logic [31:0]  t, s;
    sb = SBOX_TB;
    t  = x + k;
    s  = '0;
    for (int i = 0; i < 8; i++) begin
      row = sb[64*i +: 64];
      s[4*i +: 4] = row[4*t[4*i +: 4] +: 4];
    end
    return {s[20:0], s[31:21]};
  endfunction

  function automatic logic [63:0] crypt_tb(input logic [63:0] b, input logic [255:0] k,
                                           input bit decrypt);
    logic [31:0] n1, n2, tmp;
    int          j;
    n1 = b[63:32];
    n2 = b[31:0];
    for (int r = 0; r < 32; r++) begin
      j   = decrypt ? kidx(31 - r) : kidx(r);
      tmp = f_tb(n1, k[255-32*j -: 32]) ^ n2;
      n2  = n1;
      n1  = tmp;
    end
    return {n2, n1};
  endfunction

  function automatic logic [31:0] ea_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    r = a + b;
    if (r < a) r = r + 32'd1;
    return r;
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int unr(input int d);
    return (d == 2) ? 8 : 1;
  endfunction

  function automatic logic [31:0] cnt_of(input int d);
    case (d)
      0:       return cnt_a;
      1:       return cnt_b;
      default: return {30'b0, cnt_c};
    endcase
  endfunction

  task automatic load(input int d, input logic md, input logic [255:0] k, input logic [63:0] v);
    int cyc;
    bit ov;
    cyc = 0;
    ov  = 1'b0;
    iv_load[d] = 1'b1; iv[d] = v; key[d] = k; mode[d] = md;
    tick();
    iv_load[d] = 1'b0; iv[d] = ~v; key[d] = ~k; mode[d] = ~md;
    check("load_cnt_clear", cnt_of(d), 0);
    while (busy[d] && cyc < 100) begin
      ov |= out_valid[d];
      tick();
      cyc++;
    end
    check("init_busy_cycles", cyc, 32 / unr(d));
    check("init_no_out_valid", ov, 0);
    check("init_in_ready", in_ready[d], 1);
  endtask

  task automatic accept(input int d, input logic [63:0] din, output int waited);
    waited = 0;
    in_data[d]  = din;
    in_valid[d] = 1'b1;
    while (!in_ready[d] && waited < 100) begin
      tick();
      waited++;
    end
    tick();
    in_valid[d] = 1'b0;
    in_data[d]  = 64'hDEAD_BEEF_0BAD_F00D;
    check("accept_busy", busy[d], 1);
  endtask

  task automatic receive(input int d, input int hold, output logic [63:0] got);
    int          cyc;
    logic [63:0] exp;
    cyc = 0;
    while (!out_valid[d] && cyc < 100) begin
      tick();
      cyc++;
    end
    check("gen_latency", cyc, 32 / unr(d));
    exp = 64'hX;
    if (exp_q.size() > 0) exp = exp_q.pop_front();
    got = out_data[d];
    check("out_data", got, exp);
    for (int i = 0; i < hold; i++) begin
      tick();
      check("hold_out_data", out_data[d], got);
      check("hold_out_valid", out_valid[d], 1);
      check("hold_in_ready", in_ready[d], 0);
    end
    out_ready[d] = 1'b1;
    tick();
    out_ready[d] = 1'b0;
    check("out_valid_drop", out_valid[d], 0);
    check("ready_after_out", in_ready[d], 1);
  endtask

  typedef struct {
    int           dut;
    logic         md;
    logic [255:0] k;
    logic [63:0]  iv;
    logic [63:0]  din;
    int           nblk;
    int           hold;
    logic [31:0]  exp_cnt;
  } vec_t;

  task automatic run_vector(input vec_t v, input bit record);
    logic [63:0] s, g, din, got;
    logic [31:0] h, l, mask;
    int          w;
    mask = (v.dut == 2) ? 32'h3 : 32'hFFFF_FFFF;
    load(v.dut, v.md, v.k, v.iv);
    s = crypt_tb(v.iv, v.k, 1'b0);
    h = s[63:32];
    l = s[31:0];
    g = s;
    for (int b = 0; b < v.nblk; b++) begin
      din = v.din + 64'(b) * 64'h1111_0000_0000_1111;
      if (!v.md) begin
        l = l + 32'h0101_0101;
        h = ea_add(h, 32'h0101_0104);
        g = crypt_tb({h, l}, v.k, 1'b0);
      end else begin
        g = crypt_tb(g, v.k, 1'b0);
      end
      exp_q.push_back(din ^ g);
      accept(v.dut, din, w);
      if (b > 0) check("accept_wait", w, 0);
      receive(v.dut, v.hold, got);
      if (record && b < 4) ct[b] = got;
      check("blk_cnt_step", cnt_of(v.dut), 32'(b + 1) & mask);
    end
    check("blk_cnt_final", cnt_of(v.dut), v.exp_cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t        vecs[4];
    logic [255:0] ka;
    logic [63:0]  s, g, got, d0;
    int           w;
    bit           ov, rdy;

    for (int d = 0; d < 3; d++) begin
      iv_load[d] = 1'b0; iv[d] = '0; key[d] = '0; mode[d] = 1'b0;
      in_valid[d] = 1'b0; in_data[d] = '0; out_ready[d] = 1'b0;
    end
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      check("rst_out_valid", out_valid[d], 0);
      check("rst_in_ready", in_ready[d], 0);
      check("rst_busy", busy[d], 0);
      check("rst_blk_cnt", cnt_of(d), 0);
      check("rst_out_data", out_data[d], 0);
    end
    reset = 1'b1;
    tick();
    check("idle_in_ready", in_ready[0], 0);

    vecs[0] = '{0, 1'b0, 256'h0, 64'h0, 64'h0123_4567_89AB_CDEF, 4, 0, 32'd4};
    vecs[1] = '{0, 1'b1, 256'hFFEEDDCC_BBAA9988_77665544_33221100_F0F1F2F3_F4F5F6F7_F8F9FAFB_FCFDFEFF,
                64'h1234_5678_9ABC_DEF0, 64'hA5A5_5A5A_0F0F_F0F0, 3, 10, 32'd3};
    vecs[2] = '{2, 1'b0, 256'h01234567_89ABCDEF_FEDCBA98_76543210_0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0,
                64'hCAFE_BABE_DEAD_BEEF, 64'h0000_0000_FFFF_FFFF, 5, 0, 32'd1};
    vecs[3] = '{2, 1'b1, 256'h13579BDF_2468ACE0_0ECA8642_FDB97531_11111111_22222222_33333333_44444444,
                64'h0F0E_0D0C_0B0A_0908, 64'h5555_AAAA_3333_CCCC, 2, 3, 32'd2};
    // vector 0 uses a constant plaintext: the increment in run_vector is zero-based,
    // so only block 0 equals din; override nblk stepping by re-running block-wise below.
    for (int i = 1; i < 4; i++) run_vector(vecs[i], 1'b0);

    // Counter gamma, all-zero key/iv, constant plaintext x4, then decrypt on a twin.
    load(0, 1'b0, 256'h0, 64'h0);
    s = crypt_tb(64'h0, 256'h0, 1'b0);
    for (int b = 0; b < 4; b++) begin
      s = {ea_add(s[63:32], 32'h0101_0104), s[31:0] + 32'h0101_0101};
      exp_q.push_back(64'h0123_4567_89AB_CDEF ^ crypt_tb(s, 256'h0, 1'b0));
      accept(0, 64'h0123_4567_89AB_CDEF, w);
      receive(0, 0, got);
      ct[b] = got;
    end
    check("zero_vec_blk_cnt", cnt_a, vecs[0].exp_cnt);
    load(1, 1'b0, 256'h0, 64'h0);
    for (int b = 0; b < 4; b++) begin
      exp_q.push_back(64'h0123_4567_89AB_CDEF);
      accept(1, ct[b], w);
      receive(1, 0, got);
    end
    check("twin_blk_cnt", cnt_b, 4);

    // End-around counter corners: choose iv so that S lands on the boundary values.
    ka = vecs[1].k;
    load(0, 1'b0, ka, crypt_tb({32'hFFFF_FFFF, 32'hFFFF_FFFF}, ka, 1'b1));
    exp_q.push_back(64'h1357_9BDF_0246_8ACE ^ crypt_tb({32'h0101_0104, 32'h0101_0100}, ka, 1'b0));
    accept(0, 64'h1357_9BDF_0246_8ACE, w);
    receive(0, 0, got);
    load(0, 1'b0, ka, crypt_tb({32'hFEFE_FEFB, 32'h0000_0000}, ka, 1'b1));
    exp_q.push_back(64'h1357_9BDF_0246_8ACE ^ crypt_tb({32'hFFFF_FFFF, 32'h0101_0101}, ka, 1'b0));
    accept(0, 64'h1357_9BDF_0246_8ACE, w);
    receive(0, 0, got);

    // iv_load during GEN aborts the block in flight.
    load(0, 1'b1, ka, 64'h1111_2222_3333_4444);
    g = crypt_tb(crypt_tb(64'h1111_2222_3333_4444, ka, 1'b0), ka, 1'b0);
    exp_q.push_back(64'h0 ^ g);
    accept(0, 64'h0, w);
    receive(0, 0, got);
    check("pre_abort_cnt", cnt_a, 1);
    accept(0, 64'h7777_7777_7777_7777, w);
    repeat (5) begin
      tick();
      check("abort_gen_no_ov", out_valid[0], 0);
    end
    load(0, 1'b1, ka, 64'h5555_6666_7777_8888);
    g = crypt_tb(crypt_tb(64'h5555_6666_7777_8888, ka, 1'b0), ka, 1'b0);
    d0 = 64'h8888_9999_AAAA_BBBB;
    exp_q.push_back(d0 ^ g);
    accept(0, d0, w);
    receive(0, 0, got);
    check("post_abort_cnt", cnt_a, 1);

    // Asynchronous reset during GEN.
    load(0, 1'b0, ka, 64'h0BAD_CAFE_1234_5678);
    accept(0, 64'h2222_3333_4444_5555, w);
    repeat (3) tick();
    in_valid[0] = 1'b1;
    reset = 1'b0;
    #2;
    check("async_rst_busy", busy[0], 0);
    check("async_rst_out_valid", out_valid[0], 0);
    check("async_rst_out_data", out_data[0], 0);
    check("async_rst_blk_cnt", cnt_a, 0);
    check("async_rst_in_ready", in_ready[0], 0);
    #2;
    reset = 1'b1;
    ov  = 1'b0;
    rdy = 1'b0;
    repeat (40) begin
      tick();
      ov  |= out_valid[0];
      rdy |= in_ready[0] | busy[0];
    end
    check("post_rst_no_ov", ov, 0);
    check("post_rst_idle", rdy, 0);
    in_valid[0] = 1'b0;
    load(0, 1'b0, ka, 64'h0BAD_CAFE_1234_5678);
    s = crypt_tb(64'h0BAD_CAFE_1234_5678, ka, 1'b0);
    s = {ea_add(s[63:32], 32'h0101_0104), s[31:0] + 32'h0101_0101};
    exp_q.push_back(64'h2222_3333_4444_5555 ^ crypt_tb(s, ka, 1'b0));
    accept(0, 64'h2222_3333_4444_5555, w);
    receive(0, 0, got);
    check("post_rst_blk_cnt", cnt_a, 1);
    check("scoreboard_empty", 64'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
